// File: rtl/rv32i_instr_encoder.sv
`default_nettype none
// ============================================================================
// rv32i_instr_encoder : packs decoded RV32I fields into instruction words and
//                       streams them into instruction memory.
// Revision: 1.0
// ============================================================================
module rv32i_instr_encoder #(
   parameter int          DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          ADDR_W    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [6:0]               in_opcode,
   input  logic [2:0]               in_func3,
   input  logic                     in_func7,
   input  logic [4:0]               in_rd,
   input  logic [4:0]               in_rs1,
   input  logic [4:0]               in_rs2,
   input  logic [31:0]              in_imm,
   output logic                     imem_we,
   output logic [ADDR_W-1:0]        imem_addr,
   output logic [31:0]              imem_wdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     done,
   output logic                     err,
   output logic [1:0]               err_code
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   localparam logic [6:0] c_op_r     = 7'b0110011;
   localparam logic [6:0] c_op_imm   = 7'b0010011;
   localparam logic [6:0] c_op_load  = 7'b0000011;
   localparam logic [6:0] c_op_jalr  = 7'b1100111;
   localparam logic [6:0] c_op_store = 7'b0100011;
   localparam logic [6:0] c_op_br    = 7'b1100011;
   localparam logic [6:0] c_op_lui   = 7'b0110111;
   localparam logic [6:0] c_op_auipc = 7'b0010111;
   localparam logic [6:0] c_op_jal   = 7'b1101111;

   localparam logic [1:0] c_err_none  = 2'b00;
   localparam logic [1:0] c_err_op    = 2'b01;
   localparam logic [1:0] c_err_range = 2'b10;
   localparam logic [1:0] c_err_align = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_FULL = 2'd2
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_next_addr;

   logic signed [31:0]  w_simm;
   logic                w_imm12_ok;
   logic                w_shift;
   logic [31:0]         w_word;
   logic [1:0]          w_code;

   assign w_simm     = $signed(in_imm);
   assign w_imm12_ok = (w_simm >= -32'sd2048) && (w_simm <= 32'sd2047);
   assign w_shift    = (in_func3 == 3'b001) || (in_func3 == 3'b101);

   // Encode and validate in one pass; the first failing check sets w_code.
   always_comb begin
      w_word = 32'h0;
      w_code = c_err_none;
      case (in_opcode)
         c_op_r: begin
            w_word = {1'b0, in_func7, 5'b0, in_rs2, in_rs1, in_func3, in_rd, in_opcode};
         end
         c_op_imm: begin
            if (w_shift) begin
               // SLLI has no arithmetic variant, so its func7 bit is forced low.
               w_word = {1'b0, in_func7 & (in_func3 == 3'b101), 5'b0, in_imm[4:0],
                         in_rs1, in_func3, in_rd, in_opcode};
               if (in_imm[31:5] != 27'h0) w_code = c_err_range;
            end else begin
               w_word = {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode};
               if (!w_imm12_ok) w_code = c_err_range;
            end
         end
         c_op_load, c_op_jalr: begin
            w_word = {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode};
            if (!w_imm12_ok) w_code = c_err_range;
         end
         c_op_store: begin
            w_word = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], in_opcode};
            if (!w_imm12_ok) w_code = c_err_range;
         end
         c_op_br: begin
            w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                      in_imm[4:1], in_imm[11], in_opcode};
            if ((w_simm < -32'sd4096) || (w_simm > 32'sd4094)) w_code = c_err_range;
            else if (in_imm[0])                                 w_code = c_err_align;
         end
         c_op_lui, c_op_auipc: begin
            w_word = {in_imm[31:12], in_rd, in_opcode};
            if (in_imm[11:0] != 12'h0) w_code = c_err_range;
         end
         c_op_jal: begin
            w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            if ((w_simm < -32'sd1048576) || (w_simm > 32'sd1048574)) w_code = c_err_range;
            else if (in_imm[0])                                       w_code = c_err_align;
         end
         default: begin
            w_code = c_err_op;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_next_addr <= ADDR_W'(BASE_ADDR);
         in_ready    <= 1'b0;
         imem_we     <= 1'b0;
         imem_addr   <= ADDR_W'(BASE_ADDR);
         imem_wdata  <= 32'h0;
         count       <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
         err_code    <= c_err_none;
      end else begin
         imem_we <= 1'b0;
         // A start pulse wins over any handshake presented in the same cycle.
         if (start) begin
            r_state     <= S_LOAD;
            r_next_addr <= ADDR_W'(BASE_ADDR);
            in_ready    <= 1'b1;
            imem_addr   <= ADDR_W'(BASE_ADDR);
            count       <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= c_err_none;
         end else begin
            case (r_state)
               S_LOAD: begin
                  if (in_valid) begin
                     if (w_code != c_err_none) begin
                        err      <= 1'b1;
                        err_code <= w_code;
                     end else begin
                        imem_we     <= 1'b1;
                        imem_addr   <= r_next_addr;
                        imem_wdata  <= w_word;
                        r_next_addr <= r_next_addr + ADDR_W'(4);
                        count       <= count + CNT_W'(1);
                        if (count == CNT_W'(DEPTH - 1)) begin
                           r_state  <= S_FULL;
                           in_ready <= 1'b0;
                           done     <= 1'b1;
                        end
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_instr_encoder.sv
`default_nettype none
// ============================================================================
// tb_rv32i_instr_encoder : scoreboard bench for rv32i_instr_encoder (DEPTH=4).
// Revision: 1.0
// ============================================================================
module tb_rv32i_instr_encoder;

   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  in_opcode = '0;
   logic [2:0]  in_func3 = '0;
   logic        in_func7 = 1'b0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [31:0] in_imm = '0;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic [2:0]  count;
   logic        done, err;
   logic [1:0]  err_code;

   rv32i_instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_func3(in_func3), .in_func7(in_func7),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .count(count), .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
   wr_t q[$];

   // Expected observable state after the next rising edge
   int          m_phase = 0;   // 0 idle, 1 loading, 2 full
   int          m_count = 0;
   logic [31:0] m_addr  = BASE;
   logic        m_err   = 1'b0;
   logic [1:0]  m_code  = 2'b00;
   logic        m_done  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] ref_check(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [31:0] imm);
      int s;
      s = $signed(imm);
      case (op)
         7'h33: return 2'd0;
         7'h13: begin
            if (f3 == 3'd1 || f3 == 3'd5) return (s < 0 || s > 31) ? 2'd2 : 2'd0;
            return (s < -2048 || s > 2047) ? 2'd2 : 2'd0;
         end
         7'h03, 7'h67, 7'h23: return (s < -2048 || s > 2047) ? 2'd2 : 2'd0;
         7'h63: begin
            if (s < -4096 || s > 4094) return 2'd2;
            return (s % 2 != 0) ? 2'd3 : 2'd0;
         end
         7'h6F: begin
            if (s < -1048576 || s > 1048574) return 2'd2;
            return (s % 2 != 0) ? 2'd3 : 2'd0;
         end
         7'h37, 7'h17: return ((imm & 32'hFFF) != 0) ? 2'd2 : 2'd0;
         default: return 2'd1;
      endcase
   endfunction

   function automatic logic [31:0] ref_enc(input logic [6:0] op, input logic [2:0] f3,
                                           input logic f7, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
      logic [31:0] w;
      w = 32'(op);
      case (op)
         7'h33: w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                      | (32'(rs2) << 20) | (32'(f7) << 30);
         7'h13: begin
            if (f3 == 3'd1 || f3 == 3'd5)
               w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                     | ((imm & 32'd31) << 20) | ((f3 == 3'd5) ? (32'(f7) << 30) : 32'd0);
            else
               w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                     | ((imm & 32'hFFF) << 20);
         end
         7'h03, 7'h67: w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                             | ((imm & 32'hFFF) << 20);
         7'h23: w = w | ((imm & 32'd31) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                      | (32'(rs2) << 20) | (((imm >> 5) & 32'd127) << 25);
         7'h63: w = w | (((imm >> 11) & 32'd1) << 7) | (((imm >> 1) & 32'd15) << 8)
                      | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
                      | (((imm >> 5) & 32'd63) << 25) | (((imm >> 12) & 32'd1) << 31);
         7'h37, 7'h17: w = w | (32'(rd) << 7) | (imm & 32'hFFFFF000);
         7'h6F: w = w | (32'(rd) << 7) | (((imm >> 12) & 32'd255) << 12)
                      | (((imm >> 11) & 32'd1) << 20) | (((imm >> 1) & 32'd1023) << 21)
                      | (((imm >> 20) & 32'd1) << 31);
         default: w = 32'h0;
      endcase
      return w;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_count = 0; m_addr = BASE;
      m_err = 1'b0; m_code = 2'b00; m_done = 1'b0;
      q.delete();
   endtask

   // exp[32] set: use exp[31:0] as the expected word instead of the model
   task automatic drive(input logic st, input logic v, input logic [6:0] op,
                        input logic [2:0] f3, input logic f7, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [32:0] exp);
      logic [1:0] code;
      wr_t wr;
      @(negedge clk);
      start = st; in_valid = v; in_opcode = op; in_func3 = f3; in_func7 = f7;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      if (st) begin
         m_phase = 1; m_count = 0; m_addr = BASE;
         m_err = 1'b0; m_code = 2'b00; m_done = 1'b0;
      end else if (m_phase == 1 && v) begin
         code = ref_check(op, f3, imm);
         if (code != 2'd0) begin
            m_err = 1'b1; m_code = code;
         end else begin
            wr.addr = m_addr;
            wr.data = exp[32] ? exp[31:0] : ref_enc(op, f3, f7, rd, rs1, rs2, imm);
            q.push_back(wr);
            m_addr += 4;
            m_count++;
            if (m_count == DEPTH) begin m_phase = 2; m_done = 1'b1; end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 7'h0, 3'h0, 1'b0, 5'h0, 5'h0, 5'h0, 32'h0, 33'h0);
   endtask

   task automatic do_start();
      drive(1'b1, 1'b0, 7'h0, 3'h0, 1'b0, 5'h0, 5'h0, 5'h0, 32'h0, 33'h0);
   endtask

   task automatic check_reset_values();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_imem_we", 32'(imem_we), 32'd0);
      chk("rst_imem_addr", imem_addr, BASE);
      chk("rst_imem_wdata", imem_wdata, 32'h0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_err_code", 32'(err_code), 32'd0);
   endtask

   // Monitor: pops the scoreboard on each write and tracks status outputs
   always @(posedge clk) begin
      wr_t e;
      #1;
      if (!rst) begin
         if (imem_we) begin
            if (q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                        imem_addr, imem_wdata);
            end else begin
               e = q.pop_front();
               chk("write_addr", imem_addr, e.addr);
               chk("write_data", imem_wdata, e.data);
            end
         end else if (q.size() != 0) begin
            e = q.pop_front();
            n_checks++; n_fail++;
            $display("FAIL missing_write: got no write, expected addr 0x%08h data 0x%08h",
                     e.addr, e.data);
         end
         chk("count", 32'(count), 32'(m_count));
         chk("in_ready", 32'(in_ready), 32'(m_phase == 1));
         chk("done", 32'(done), 32'(m_done));
         chk("err", 32'(err), 32'(m_err));
         chk("err_code", 32'(err_code), 32'(m_code));
      end
   end

   function automatic logic [31:0] gen_imm(input logic [6:0] op, input logic [2:0] f3);
      int bnd[19] = '{-1048578, -1048577, -1048576, 1048574, 1048575, -4097, -4096,
                      4094, 4095, 4096, -2049, -2048, 2047, 2048, 31, 32, -1, 0, 1};
      int t;
      case ($urandom_range(0, 3))
         0: return $urandom;
         3: return bnd[$urandom_range(0, 18)];
         default: begin
            case (op)
               7'h13: begin
                  if (f3 == 3'd1 || f3 == 3'd5) return $urandom_range(0, 31);
                  t = $urandom_range(0, 4095); return t - 2048;
               end
               7'h63: begin t = $urandom_range(0, 4095); return (t - 2048) * 2; end
               7'h6F: begin t = $urandom_range(0, 1048575); return (t - 524288) * 2; end
               7'h37, 7'h17: return $urandom & 32'hFFFFF000;
               default: begin t = $urandom_range(0, 4095); return t - 2048; end
            endcase
         end
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [6:0] ops[13] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                              7'h6F, 7'h7F, 7'h00, 7'h0F, 7'h73};
      logic       st, v, f7;
      logic [6:0] op;
      logic [2:0] f3;
      logic [31:0] imm;

      // Reset state
      #3;
      check_reset_values();
      @(negedge clk); rst = 1'b0;
      idle(2);

      // First word of a session
      do_start();
      drive(1'b0, 1'b1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, {1'b1, 32'h00500093});

      // Back-to-back sub / sw from a fresh session
      do_start();
      drive(1'b0, 1'b1, 7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, {1'b1, 32'h402081B3});
      drive(1'b0, 1'b1, 7'h23, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, {1'b1, 32'h0020A423});

      // beq / lui / srai, then rejections, then fill to full and overflow attempt
      do_start();
      drive(1'b0, 1'b1, 7'h63, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, -32'sd4, {1'b1, 32'hFE000EE3});
      drive(1'b0, 1'b1, 7'h37, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, {1'b1, 32'h123452B7});
      drive(1'b0, 1'b1, 7'h13, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3, {1'b1, 32'h4030D093});
      drive(1'b0, 1'b1, 7'h63, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd3, 33'h0);
      drive(1'b0, 1'b1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 33'h0);
      drive(1'b0, 1'b1, 7'h7F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 33'h0);
      drive(1'b0, 1'b1, 7'h13, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7, 33'h0);
      drive(1'b0, 1'b1, 7'h13, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd9, 33'h0);

      // Five valid descriptors into a 4-deep session
      do_start();
      for (int k = 0; k < 5; k++)
         drive(1'b0, 1'b1, 7'h13, 3'd0, 1'b0, 5'(k + 1), 5'd0, 5'd0, 32'(k), 33'h0);
      idle(2);
      do_start();
      idle(1);

      // Reset landing on a pending write
      drive(1'b0, 1'b1, 7'h13, 3'd0, 1'b0, 5'd4, 5'd4, 5'd0, 32'd100, 33'h0);
      @(posedge clk);
      #2 rst = 1'b1; in_valid = 1'b0;
      model_reset();
      #1 check_reset_values();
      @(negedge clk); rst = 1'b0;
      drive(1'b0, 1'b1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 33'h0);
      drive(1'b0, 1'b1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2, 33'h0);

      // Randomized traffic with session restarts
      for (int i = 0; i < 600; i++) begin
         st  = (m_phase != 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
         v   = ($urandom_range(0, 3) != 0);
         op  = ops[$urandom_range(0, 12)];
         f3  = 3'($urandom_range(0, 7));
         f7  = 1'($urandom_range(0, 1));
         imm = gen_imm(op, f3);
         drive(st, v, op, f3, f7, 5'($urandom), 5'($urandom), 5'($urandom), imm, 33'h0);
      end

      idle(3);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
